// File: rtl/mux32_rr_sched_if.sv
// Handshake/bus bundle between the 32 lane producers, the scheduler and the downstream consumer.
// Latency: none, wires only.
// Backpressure: out_ready from the consumer is folded into req_ready by the scheduler.
interface mux32_rr_sched_if;
   logic [31:0] req_valid;
   logic [31:0] req_last;
   logic [31:0] req_ready;
   logic        out_ready;
   logic        out_valid;
   logic        out_last;
   logic [4:0]  sel;
   logic [31:0] grant;
   logic        busy;

   // Environment side: producers drive requests, consumer drives out_ready.
   modport master (
      output req_valid, req_last, out_ready,
      input  req_ready, out_valid, out_last, sel, grant, busy
   );

   // Scheduler side.
   modport slave (
      input  req_valid, req_last, out_ready,
      output req_ready, out_valid, out_last, sel, grant, busy
   );
endinterface

// File: rtl/mux32_rr_sched.sv
// Round-robin burst scheduler driving the select of a shared 32:1 mux; optional stall timeout via MUX32_SCHED_TIMEOUT_EN.
// Latency: grant/sel one cycle after req_valid seen in IDLE; one idle bubble between bursts.
// Backpressure: out_ready=0 holds the burst and grant; only the granted lane ever sees req_ready.
module mux32_rr_sched #(
   parameter int TIMEOUT = 64
) (
   input logic            clk,
   input logic            rst,
   mux32_rr_sched_if.slave bus
);

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t      state;
   logic [31:0] grant;
   logic [4:0]  sel;
   logic        busy;
   logic [4:0]  ptr;
   logic [4:0]  winner;
   logic        out_valid;
   logic        beat_last_done;

   // Stall limit must fit the 8-bit counter and leave at least one idle beat.
   if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
      $error("mux32_rr_sched: TIMEOUT out of range 2..255");
   end

`ifdef MUX32_SCHED_TIMEOUT_EN
   logic [7:0] stall_cnt;
   localparam logic [7:0] STALL_LIMIT = 8'(TIMEOUT - 1);
`endif

   // Winner search: scan downward in distance so the nearest set bit above ptr wins; distance 32 is ptr itself.
   always_comb begin
      winner = ptr;
      for (int k = 32; k >= 1; k--) begin
         if (bus.req_valid[5'(ptr + 5'(k))]) begin
            winner = 5'(ptr + 5'(k));
         end
      end
   end

   // Output handshake; reset blocks any acceptance in the cycle it is asserted.
   assign out_valid      = ~rst & busy & bus.req_valid[sel];
   assign beat_last_done = out_valid & bus.out_ready & bus.req_last[sel];

   assign bus.out_valid  = out_valid;
   assign bus.out_last   = out_valid & bus.req_last[sel];
   assign bus.req_ready  = grant & {32{~rst & busy & bus.out_ready}};
   assign bus.grant      = grant;
   assign bus.sel        = sel;
   assign bus.busy       = busy;

   // Two-state arbiter FSM with registered grant/sel/busy; ptr only moves when a new burst starts.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         busy  <= 1'b0;
         sel   <= '0;
         ptr   <= 5'd31;
`ifdef MUX32_SCHED_TIMEOUT_EN
         stall_cnt <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (|bus.req_valid) begin
                  state <= BURST;
                  busy  <= 1'b1;
                  grant <= 32'd1 << winner;
                  sel   <= winner;
                  ptr   <= winner;
`ifdef MUX32_SCHED_TIMEOUT_EN
                  stall_cnt <= '0;
`endif
               end
            end
            BURST: begin
               if (beat_last_done) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  grant <= '0;
               end
`ifdef MUX32_SCHED_TIMEOUT_EN
               else if (!bus.req_valid[sel]) begin
                  // Stalled lane gives up the grant; ptr stays so it ranks last next round.
                  if (stall_cnt == STALL_LIMIT) begin
                     state     <= IDLE;
                     busy      <= 1'b0;
                     grant     <= '0;
                     stall_cnt <= '0;
                  end else begin
                     stall_cnt <= stall_cnt + 8'd1;
                  end
               end else begin
                  stall_cnt <= '0;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux32_rr_sched.sv
// Directed plus randomized bench for mux32_rr_sched against a behavioural scheduler model.
// Latency: model tracks owner/pointer per cycle; outputs compared mid-cycle.
// Backpressure: out_ready toggled directed and random.
module tb_mux32_rr_sched;

`ifdef MUX32_SCHED_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 64;
`endif

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   mux32_rr_sched_if bus_if();

   mux32_rr_sched #(.TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   // Reference model: who owns the mux, last winner, stalled-cycle count.
   bit m_busy;
   int m_ptr;
   int m_sel;
   int m_stall;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_check();
      logic [31:0] e_grant;
      logic [31:0] e_rr;
      logic        e_ov;
      logic        e_ol;
      e_grant = m_busy ? (32'd1 << m_sel) : 32'd0;
      e_ov    = !rst && m_busy && bus_if.req_valid[m_sel];
      e_ol    = e_ov && bus_if.req_last[m_sel];
      e_rr    = (!rst && m_busy && bus_if.out_ready) ? (32'd1 << m_sel) : 32'd0;
      chk("grant",     bus_if.grant,            e_grant);
      chk("sel",       32'(bus_if.sel),         32'(m_sel));
      chk("busy",      32'(bus_if.busy),        32'(m_busy));
      chk("out_valid", 32'(bus_if.out_valid),   32'(e_ov));
      chk("out_last",  32'(bus_if.out_last),    32'(e_ol));
      chk("req_ready", bus_if.req_ready,        e_rr);
   endtask

   task automatic model_update();
      bit found;
      int c;
      if (rst) begin
         m_busy  = 0;
         m_ptr   = 31;
         m_sel   = 0;
         m_stall = 0;
      end else if (!m_busy) begin
         found = 0;
         for (int k = 1; k <= 32; k++) begin
            c = (m_ptr + k) % 32;
            if (!found && bus_if.req_valid[c]) begin
               found   = 1;
               m_busy  = 1;
               m_ptr   = c;
               m_sel   = c;
               m_stall = 0;
            end
         end
      end else begin
         if (bus_if.req_valid[m_sel] && bus_if.out_ready && bus_if.req_last[m_sel]) begin
            m_busy = 0;
         end
`ifdef MUX32_SCHED_TIMEOUT_EN
         else if (!bus_if.req_valid[m_sel]) begin
            m_stall = m_stall + 1;
            if (m_stall >= TO) begin
               m_busy  = 0;
               m_stall = 0;
            end
         end else begin
            m_stall = 0;
         end
`endif
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_update();
      #1;
   endtask

   initial begin
      bit pat [7];
      int beats;
      clk = 0;
      errors = 0;
      checks = 0;
      rst = 1;
      bus_if.req_valid = '0;
      bus_if.req_last  = '0;
      bus_if.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      m_busy = 0; m_ptr = 31; m_sel = 0; m_stall = 0;
      step();                                   // reset state checked by model
      chk("reset_grant", bus_if.grant, 32'd0);
      chk("reset_sel",   32'(bus_if.sel), 32'd0);
      rst = 0;

      // Requester 0, three-beat burst, then one-cycle bubble before re-grant.
      bus_if.req_valid = 32'h1;
      bus_if.out_ready = 1'b1;
      step();
      chk("t1_grant", bus_if.grant, 32'h1);
      chk("t1_sel",   32'(bus_if.sel), 32'd0);
      for (int b = 0; b < 3; b++) begin
         bus_if.req_last = (b == 2) ? 32'h1 : 32'h0;
         step();
         chk("t1_busy", 32'(bus_if.busy), (b == 2) ? 32'd0 : 32'd1);
      end
      bus_if.req_last = '0;
      step();
      chk("t1_regrant", bus_if.grant, 32'h1);
      rst = 1; step(); rst = 0;

      // All requesting, single-beat bursts: 0..31 then 0 again.
      bus_if.req_valid = '1;
      bus_if.req_last  = '1;
      for (int i = 0; i <= 32; i++) begin
         step();
         chk("t2_sel",   32'(bus_if.sel), 32'(i % 32));
         chk("t2_grant", bus_if.grant, 32'd1 << (i % 32));
         step();
         chk("t2_idle",  32'(bus_if.busy), 32'd0);
      end
      bus_if.req_valid = '0;
      rst = 1; step(); rst = 0;

      // Only requester 31 with ptr at 31: it wins twice in a row.
      bus_if.req_valid = 32'h8000_0000;
      for (int r = 0; r < 2; r++) begin
         step();
         chk("t4_sel", 32'(bus_if.sel), 32'd31);
         step();
      end
      bus_if.req_valid = '0;
      step();

      // Requester 5, four beats under toggling out_ready; requester 2 arrives mid-burst.
      bus_if.req_valid = 32'h20;
      bus_if.req_last  = '0;
      step();
      chk("t3_grant", bus_if.grant, 32'h20);
      pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      beats = 0;
      for (int p = 0; p < 7; p++) begin
         bus_if.out_ready = pat[p];
         bus_if.req_valid = 32'h20 | ((p >= 1) ? 32'h4 : 32'h0);
         bus_if.req_last  = (beats == 3) ? 32'h20 : 32'h0;
         step();
         chk("t3_rr2", 32'(bus_if.req_ready[2]), 32'd0);
         if (p < 6) chk("t3_hold", bus_if.grant, 32'h20);
         else       chk("t3_done", 32'(bus_if.busy), 32'd0);
         if (pat[p]) beats++;
      end
      bus_if.req_valid = 32'h4;
      bus_if.req_last  = '0;
      bus_if.out_ready = 1'b1;
      step();
      chk("t3_next", bus_if.grant, 32'h4);

      // Close that burst, then reset on the second beat of requester 7.
      bus_if.req_last = 32'h4;
      step();
      bus_if.req_valid = 32'h80;
      bus_if.req_last  = '0;
      step();
      chk("t5_grant", bus_if.grant, 32'h80);
      step();
      rst = 1;
      step();
      chk("t5_rst_grant", bus_if.grant, 32'd0);
      rst = 0;
      bus_if.req_valid = 32'h81;
      chk("t5_rst_ov", 32'(bus_if.out_valid), 32'd0);
      step();
      chk("t5_prio0", bus_if.grant, 32'h1);
      bus_if.req_last = 32'h1;
      step();
      bus_if.req_valid = '0;
      bus_if.req_last  = '0;
      step();

`ifdef MUX32_SCHED_TIMEOUT_EN
      // Requester 9 stalls after one beat; requester 10 takes over after the timeout.
      bus_if.req_valid = 32'h200;
      step();
      chk("to_grant9", bus_if.grant, 32'h200);
      bus_if.req_valid = 32'h600;
      step();
      bus_if.req_valid = 32'h400;
      for (int s = 1; s <= 4; s++) begin
         step();
         chk("to_busy", 32'(bus_if.busy), (s < 4) ? 32'd1 : 32'd0);
      end
      step();
      chk("to_grant10", bus_if.grant, 32'h400);
      bus_if.req_last = 32'h400;
      step();
      bus_if.req_valid = '0;
      bus_if.req_last  = '0;
      step();
`endif

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         bus_if.req_valid = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom & $urandom);
         bus_if.req_last  = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom & $urandom & $urandom);
         bus_if.out_ready = ($urandom_range(0, 3) != 0);
         rst              = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mux32_rr_sched.md
# mux32_rr_sched

Round-robin scheduler that shares one `mux_32to1` datapath between 32 requesters. It picks a requester, drives the registered 5-bit select into the mux, and holds the grant for a multi-beat burst until the requester marks the last beat. It also generates the per-requester ready and the merged output valid. It sits between the 32 lane producers and the single downstream consumer, for example the hash-bank result collector feeding the Huffman encoder.

## Interface
Parameters:
- `TIMEOUT`, 64: idle-stall limit in cycles for a granted requester. Used only when `MUX32_SCHED_TIMEOUT_EN` is defined. Legal range 2..255.

Ports:
- `clk`  in  1: single clock; all logic rising-edge.
- `rst`  in  1: reset, synchronous, active-high.
- `req_valid`  in  32: bit i = requester i has a beat on its mux input `din<i>`.
- `req_last`  in  32: bit i = current beat of requester i ends its burst. Sampled only with `req_valid[i]`.
- `req_ready`  out  32: bit i = beat of requester i accepted this cycle.
- `out_ready`  in  1: downstream accepts the mux output.
- `out_valid`  out  1: mux output `dout` carries a valid beat.
- `out_last`  out  1: the valid beat is the last of its burst.
- `sel`  out  5: registered select, wired to `mux_32to1.sel`.
- `grant`  out  32: one-hot registered grant; all-zero when idle.
- `busy`  out  1: a grant is held.

## Operation
- FSM has two states.
  - IDLE: `grant`=0, `busy`=0. If `req_valid`≠0, pick the winner and go to BURST. Otherwise stay in IDLE.
  - BURST: `grant` and `sel` are held constant. Move to IDLE on the accepted last beat, or on timeout.
- Winner selection:
  - The winner is the first set bit of `req_valid`, searching upward from `ptr+1` and wrapping from 31 to 0.
  - On entry to BURST, `ptr` ← winner, `sel` ← winner, `grant` ← one-hot(winner).
  - If the only requester is `ptr` itself, it wins, because the search wraps back to it last.
- Output handshake:
  - `out_valid` = BURST & `req_valid[sel]`.
  - `out_last` = `out_valid` & `req_last[sel]`.
  - `req_ready` = `grant` & {32{BURST & `out_ready`}}.
- Transfer rule: a beat transfers when `out_valid` & `out_ready`. Only the granted requester ever sees ready.
- Requesters may deassert `req_valid` mid-burst (a bubble). The grant is still held.
- Non-granted requesters wait. Their `req_valid` has no effect until the next IDLE cycle.
- `sel` keeps its last value in IDLE; the mux output is don't-care when `out_valid`=0.

## Timing
- Reset values: `grant`=0, `busy`=0, `out_valid`=0, `out_last`=0, `req_ready`=0, `sel`=0, `ptr`=31 (requester 0 has first priority), FSM=IDLE, timeout counter=0.
- Reset asserted mid-burst: the next cycle is IDLE with all outputs at reset values. No beat is accepted in the reset cycle.
- Arbitration latency: `req_valid` seen in IDLE at cycle t gives `grant`/`sel` at t+1, and the earliest transfer is at t+1.
- Throughput: one beat per cycle within a burst.
- Burst switch: last beat accepted at t, IDLE at t+1, next grant at t+2. This is a fixed one-cycle bubble between bursts.
- A single-beat burst (`req_last` on the first beat) occupies exactly one BURST cycle if `out_ready`=1.
- `out_ready`=0 stalls the burst indefinitely with grant held; the timeout does not count these cycles.
- The combinational paths are `req_valid`/`req_last`/`out_ready` → `out_valid`/`out_last`/`req_ready`. `sel` and `grant` are purely registered.

## Configuration
- `MUX32_SCHED_TIMEOUT_EN` defined:
  - An 8-bit counter increments each BURST cycle where `req_valid[sel]`=0. It clears on any cycle with `req_valid[sel]`=1 and on entering BURST.
  - When the counter reaches `TIMEOUT`, the FSM goes to IDLE next cycle, the grant is dropped, and `ptr` is kept, so the stalled requester has lowest priority next round.
- Undefined: no counter. A granted requester keeps the grant until its last beat is accepted or `rst` is asserted.

## Test plan
- Reset, then `req_valid`=0x0000_0001 with a 3-beat burst and `out_ready`=1 → `grant`=0x1, `sel`=0, three transfers on consecutive cycles, then IDLE for 1 cycle.
- `req_valid`=0xFFFF_FFFF held, all bursts 1 beat → grant order 0,1,2,…,31,0 with one IDLE cycle between grants, and `sel` matches the grant each time.
- Requester 5 granted in a 4-beat burst, requester 2 asserts mid-burst, `out_ready` toggles 1,0,1,0 → no grant change until the 4th beat is accepted, and `req_ready[2]` stays 0. Requester 2 is granted next.
- `ptr`=31, only `req_valid[31]` set → requester 31 wins again (wrap case), `sel`=31.
- `rst` pulsed on the 2nd beat of a burst from requester 7 → the next cycle has `grant`=0 and `out_valid`=0; after release, requester 0 has priority over 7.
- With `MUX32_SCHED_TIMEOUT_EN` and `TIMEOUT`=4: requester 9 granted, sends 1 beat, then drops `req_valid` → grant released after 4 stalled cycles, and a pending requester 10 is granted 2 cycles later.
